// File: rtl/zoom_engine_if.sv
// Request/status and frame-memory bus of the zoom engine.
// Handshake: start is a 1-cycle request honoured only while busy=0 and done=0; the operation
// ends with a 1-cycle done pulse (err qualifies it); mem_rdata answers mem_addr one cycle later.
interface zoom_engine_if #(
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 18,
    parameter int DIM_W  = 10
);
    logic              start;
    logic              abort;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] src_base;
    logic [ADDR_W-1:0] dst_base;
    logic [DIM_W-1:0]  src_w;
    logic [DIM_W-1:0]  src_h;
    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_wdata;
    logic              mem_we;
    logic [PIX_W-1:0]  mem_rdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [2:0]        state_dbg;

    modport master (
        output start, abort, mode, src_base, dst_base, src_w, src_h, mem_rdata,
        input  mem_addr, mem_wdata, mem_we, busy, done, err, state_dbg
    );

    modport slave (
        input  start, abort, mode, src_base, dst_base, src_w, src_h, mem_rdata,
        output mem_addr, mem_wdata, mem_we, busy, done, err, state_dbg
    );
endinterface

// File: rtl/zoom_engine.sv
// Window scaler over a single-port frame memory: replicate (zoom in), block average or
// decimate (zoom out), or 1:1 copy, with row bases accumulated by stride additions.
module zoom_engine #(
    parameter int PIX_W       = 8,
    parameter int ADDR_W      = 18,
    parameter int DIM_W       = 10,
    parameter int SRC_STRIDE  = 320,
    parameter int DST_STRIDE  = 320,
    parameter int FACTOR_LOG2 = 1
) (
    input  logic          clock,
    input  logic          reset_n,
    zoom_engine_if.slave  bus
);
    localparam int ACC_W = PIX_W + 2 * FACTOR_LOG2;
    localparam logic [1:0] M_REP = 2'b00;
    localparam logic [1:0] M_AVG = 2'b01;
    localparam logic [1:0] M_DEC = 2'b10;
    localparam logic [ADDR_W-1:0] SRC_ROW_STEP = ADDR_W'(SRC_STRIDE);
    localparam logic [ADDR_W-1:0] SRC_BLK_STEP = ADDR_W'(SRC_STRIDE << FACTOR_LOG2);
    localparam logic [ADDR_W-1:0] DST_ROW_STEP = ADDR_W'(DST_STRIDE);
    localparam logic [ADDR_W-1:0] DST_BLK_STEP = ADDR_W'(DST_STRIDE << FACTOR_LOG2);

    // NEXT has no cycle of its own: counters advance in the last WR so per-pixel timing holds.
    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_NEXT, S_FIN} state_t;

    state_t state_q, state_d;
    logic [1:0]             mode_q, mode_d;
    logic [DIM_W-1:0]       nx_q, nx_d, ny_q, ny_d, x_q, x_d, y_q, y_d;
    logic [FACTOR_LOG2-1:0] i_q, i_d, j_q, j_d;
    logic [ADDR_W-1:0]      src_row_q, src_row_d, src_sub_q, src_sub_d;
    logic [ADDR_W-1:0]      dst_row_q, dst_row_d, dst_sub_q, dst_sub_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [PIX_W-1:0]       pix_q, pix_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   err_q, err_d;

    logic              in_blk, blk_mode, dims_bad;
    logic              i_last, j_last, x_last, y_last, wr_last;
    logic [ADDR_W-1:0] x_off, x_blk, rd_addr, wr_addr, src_step, dst_step;
    logic [ACC_W-1:0]  avg_sum;
    logic [PIX_W-1:0]  avg_res;

    assign in_blk   = (bus.mode == M_AVG) || (bus.mode == M_DEC);
    assign blk_mode = (mode_q == M_AVG) || (mode_q == M_DEC);
    assign dims_bad = (bus.src_w == '0) || (bus.src_h == '0) ||
                      (in_blk && ((bus.src_w[FACTOR_LOG2-1:0] != '0) ||
                                  (bus.src_h[FACTOR_LOG2-1:0] != '0)));
    assign i_last   = &i_q;
    assign j_last   = &j_q;
    assign x_last   = (x_q == nx_q - 1'b1);
    assign y_last   = (y_q == ny_q - 1'b1);
    assign wr_last  = (mode_q != M_REP) || (i_last && j_last);
    assign x_off    = ADDR_W'(x_q);
    assign x_blk    = x_off << FACTOR_LOG2;
    assign rd_addr  = src_sub_q + (blk_mode ? x_blk + ADDR_W'(i_q) : x_off);
    assign wr_addr  = (mode_q == M_REP) ? dst_sub_q + x_blk + ADDR_W'(i_q) : dst_row_q + x_off;
    assign src_step = blk_mode ? SRC_BLK_STEP : SRC_ROW_STEP;
    assign dst_step = (mode_q == M_REP) ? DST_BLK_STEP : DST_ROW_STEP;
    assign avg_sum  = acc_q + ACC_W'(bus.mem_rdata);
    assign avg_res  = PIX_W'(avg_sum >> (2 * FACTOR_LOG2));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.start) state_d = dims_bad ? S_FIN : S_RD;
            S_RD: begin
                if (bus.abort)                                         state_d = S_IDLE;
                else if ((mode_q == M_AVG) && !(i_last && j_last))     state_d = S_RD;
                else                                                   state_d = S_CAP;
            end
            S_CAP:   state_d = bus.abort ? S_IDLE : S_WR;
            S_WR: begin
                if (bus.abort)           state_d = S_IDLE;
                else if (!wr_last)       state_d = S_WR;
                else if (x_last && y_last) state_d = S_FIN;
                else                     state_d = S_RD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mode_d    = mode_q;
        nx_d      = nx_q;
        ny_d      = ny_q;
        x_d       = x_q;
        y_d       = y_q;
        i_d       = i_q;
        j_d       = j_q;
        src_row_d = src_row_q;
        src_sub_d = src_sub_q;
        dst_row_d = dst_row_q;
        dst_sub_d = dst_sub_q;
        acc_d     = acc_q;
        pix_d     = pix_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: if (bus.start) begin
                mode_d    = bus.mode;
                nx_d      = in_blk ? (bus.src_w >> FACTOR_LOG2) : bus.src_w;
                ny_d      = in_blk ? (bus.src_h >> FACTOR_LOG2) : bus.src_h;
                x_d       = '0;
                y_d       = '0;
                i_d       = '0;
                j_d       = '0;
                src_row_d = bus.src_base;
                src_sub_d = bus.src_base;
                dst_row_d = bus.dst_base;
                dst_sub_d = bus.dst_base;
                err_d     = dims_bad;
            end
            S_RD: if (mode_q == M_AVG) begin
                // Data of the previous issue arrives now; the first issue of a block has none.
                acc_d = ((i_q == '0) && (j_q == '0)) ? '0 : avg_sum;
                if (i_last) begin
                    i_d = '0;
                    if (j_last) begin
                        j_d       = '0;
                        src_sub_d = src_row_q;
                    end else begin
                        j_d       = j_q + 1'b1;
                        src_sub_d = src_sub_q + SRC_ROW_STEP;
                    end
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            S_CAP: pix_d = (mode_q == M_AVG) ? avg_res : bus.mem_rdata;
            S_WR: begin
                if (mode_q == M_REP) begin
                    if (i_last) begin
                        i_d = '0;
                        if (j_last) begin
                            j_d       = '0;
                            dst_sub_d = dst_row_q;
                        end else begin
                            j_d       = j_q + 1'b1;
                            dst_sub_d = dst_sub_q + DST_ROW_STEP;
                        end
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end
                if (wr_last) begin
                    if (x_last) begin
                        x_d = '0;
                        if (!y_last) begin
                            y_d       = y_q + 1'b1;
                            src_row_d = src_row_q + src_step;
                            src_sub_d = src_row_q + src_step;
                            dst_row_d = dst_row_q + dst_step;
                            dst_sub_d = dst_row_q + dst_step;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.mem_we    = (state_q == S_WR);
        bus.mem_wdata = pix_q;
        bus.busy      = (state_q == S_RD) || (state_q == S_CAP) || (state_q == S_WR);
        bus.done      = (state_q == S_FIN);
        bus.err       = err_q;
        bus.state_dbg = state_q;
        case (state_q)
            S_RD:    bus.mem_addr = rd_addr;
            S_WR:    bus.mem_addr = wr_addr;
            default: bus.mem_addr = addr_q;
        endcase
        addr_d = bus.mem_addr;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mode_q    <= '0;
            nx_q      <= '0;
            ny_q      <= '0;
            x_q       <= '0;
            y_q       <= '0;
            i_q       <= '0;
            j_q       <= '0;
            src_row_q <= '0;
            src_sub_q <= '0;
            dst_row_q <= '0;
            dst_sub_q <= '0;
            acc_q     <= '0;
            pix_q     <= '0;
            addr_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            nx_q      <= nx_d;
            ny_q      <= ny_d;
            x_q       <= x_d;
            y_q       <= y_d;
            i_q       <= i_d;
            j_q       <= j_d;
            src_row_q <= src_row_d;
            src_sub_q <= src_sub_d;
            dst_row_q <= dst_row_d;
            dst_sub_q <= dst_sub_d;
            acc_q     <= acc_d;
            pix_q     <= pix_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
        end
    end
endmodule

// File: tb/tb_zoom_engine.sv
// Bench for zoom_engine: K=2 and K=4 instances share one frame-memory model, a write-order
// scoreboard and a plain-arithmetic reference of each scaling mode.
module tb_zoom_engine;
    localparam int PIX_W  = 8;
    localparam int ADDR_W = 18;
    localparam int DIM_W  = 10;
    localparam int STRIDE = 320;
    localparam int MEM_N  = 1 << ADDR_W;
    localparam int E_W    = ADDR_W + PIX_W;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic              sel = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [1:0]        mode = 2'b00;
    logic [ADDR_W-1:0] src_base = '0;
    logic [ADDR_W-1:0] dst_base = '0;
    logic [DIM_W-1:0]  src_w = '0;
    logic [DIM_W-1:0]  src_h = '0;
    logic [PIX_W-1:0]  rdata_q = '0;

    zoom_engine_if #(.PIX_W(PIX_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W)) bus2 ();
    zoom_engine_if #(.PIX_W(PIX_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W)) bus4 ();

    zoom_engine #(.FACTOR_LOG2(1)) dut_k2 (.clock(clock), .reset_n(reset_n), .bus(bus2.slave));
    zoom_engine #(.FACTOR_LOG2(2)) dut_k4 (.clock(clock), .reset_n(reset_n), .bus(bus4.slave));

    assign bus2.start = start & ~sel;
    assign bus4.start = start & sel;
    assign bus2.abort = abort & ~sel;
    assign bus4.abort = abort & sel;
    assign bus2.mode = mode;
    assign bus4.mode = mode;
    assign bus2.src_base = src_base;
    assign bus4.src_base = src_base;
    assign bus2.dst_base = dst_base;
    assign bus4.dst_base = dst_base;
    assign bus2.src_w = src_w;
    assign bus4.src_w = src_w;
    assign bus2.src_h = src_h;
    assign bus4.src_h = src_h;
    assign bus2.mem_rdata = rdata_q;
    assign bus4.mem_rdata = rdata_q;

    wire [ADDR_W-1:0] mon_addr  = sel ? bus4.mem_addr  : bus2.mem_addr;
    wire [PIX_W-1:0]  mon_wdata = sel ? bus4.mem_wdata : bus2.mem_wdata;
    wire              mon_we    = sel ? bus4.mem_we    : bus2.mem_we;
    wire              mon_busy  = sel ? bus4.busy      : bus2.busy;
    wire              mon_done  = sel ? bus4.done      : bus2.done;
    wire              mon_err   = sel ? bus4.err       : bus2.err;

    logic [PIX_W-1:0] mem [0:MEM_N-1];
    logic [E_W-1:0]   exp_q[$];
    logic [E_W-1:0]   model_q[$];
    int n_checks = 0;
    int n_fail = 0;

    // ---------------- frame memory model ----------------
    always @(posedge clock) begin
        rdata_q <= mem[mon_addr];
        if (mon_we) mem[mon_addr] = mon_wdata;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clock) begin
        logic [E_W-1:0] e;
        if (reset_n && mon_we) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data %0d, expected no write",
                         mon_addr, mon_wdata);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", int'(mon_addr), int'(e[E_W-1:PIX_W]));
                check("write_data", int'(mon_wdata), int'(e[PIX_W-1:0]));
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic int wa(input int a);
        return a & (MEM_N - 1);
    endfunction

    function automatic logic [E_W-1:0] mk(input int a, input int d);
        logic [E_W-1:0] r;
        r = {a[ADDR_W-1:0], d[PIX_W-1:0]};
        return r;
    endfunction

    task automatic model_op(input int m, input int sb, input int db, input int w, input int h,
                            input int l, output int nbusy, output bit bad);
        int k, sum;
        k = 1 << l;
        model_q.delete();
        nbusy = 0;
        bad = (w == 0) || (h == 0) || ((m == 1 || m == 2) && ((w % k) != 0 || (h % k) != 0));
        if (!bad) begin
            case (m)
                0: begin
                    for (int y = 0; y < h; y++)
                        for (int x = 0; x < w; x++)
                            for (int j = 0; j < k; j++)
                                for (int i = 0; i < k; i++)
                                    model_q.push_back(mk(wa(db + (k*y + j)*STRIDE + k*x + i),
                                                         int'(mem[wa(sb + y*STRIDE + x)])));
                    nbusy = w * h * (k*k + 2);
                end
                1: begin
                    for (int oy = 0; oy < h/k; oy++)
                        for (int ox = 0; ox < w/k; ox++) begin
                            sum = 0;
                            for (int j = 0; j < k; j++)
                                for (int i = 0; i < k; i++)
                                    sum += int'(mem[wa(sb + (k*oy + j)*STRIDE + k*ox + i)]);
                            model_q.push_back(mk(wa(db + oy*STRIDE + ox), sum / (k*k)));
                        end
                    nbusy = (w/k) * (h/k) * (k*k + 2);
                end
                2: begin
                    for (int oy = 0; oy < h/k; oy++)
                        for (int ox = 0; ox < w/k; ox++)
                            model_q.push_back(mk(wa(db + oy*STRIDE + ox),
                                                 int'(mem[wa(sb + k*oy*STRIDE + k*ox)])));
                    nbusy = (w/k) * (h/k) * 3;
                end
                default: begin
                    for (int y = 0; y < h; y++)
                        for (int x = 0; x < w; x++)
                            model_q.push_back(mk(wa(db + y*STRIDE + x),
                                                 int'(mem[wa(sb + y*STRIDE + x)])));
                    nbusy = w * h * 3;
                end
            endcase
        end
    endtask

    // ---------------- driver ----------------
    task automatic run_op(input int s, input int m, input int sb, input int db, input int w,
                          input int h, input int keep, input int abort_at, input bit mid_start,
                          input bit with_abort);
        int nbusy, busy_cnt, cyc, n, idle_bad;
        bit bad, done_seen, aborted;
        model_op(m, sb, db, w, h, (s != 0) ? 2 : 1, nbusy, bad);
        n = (keep < 0) ? model_q.size() : keep;
        for (int i = 0; i < n; i++) exp_q.push_back(model_q[i]);
        @(posedge clock);
        #1;
        sel = (s != 0);
        mode = 2'(m);
        src_base = ADDR_W'(sb);
        dst_base = ADDR_W'(db);
        src_w = DIM_W'(w);
        src_h = DIM_W'(h);
        start = 1'b1;
        abort = with_abort;
        @(posedge clock);
        #1;
        start = 1'b0;
        abort = 1'b0;
        busy_cnt = 0;
        cyc = 0;
        done_seen = 0;
        aborted = 0;
        while (cyc < 20000) begin
            @(negedge clock);
            cyc++;
            if (abort) begin
                check("abort_busy", int'(mon_busy), 0);
                check("abort_we", int'(mon_we), 0);
                check("abort_done", int'(mon_done), 0);
                abort = 1'b0;
                aborted = 1;
                break;
            end
            if (mon_done) begin
                done_seen = 1;
                break;
            end
            if (mon_busy) busy_cnt++;
            if (mid_start) begin
                start = (busy_cnt == 3);
                mode = (busy_cnt == 3) ? 2'(m) ^ 2'b11 : 2'(m);
            end
            if (abort_at != 0 && busy_cnt == abort_at) abort = 1'b1;
        end
        start = 1'b0;
        if (abort_at != 0) begin
            check("abort_reached", int'(aborted), 1);
            idle_bad = 0;
            repeat (4) begin
                @(negedge clock);
                if (mon_done || mon_busy) idle_bad++;
            end
            check("post_abort_idle", idle_bad, 0);
        end else begin
            check("done_seen", int'(done_seen), 1);
            check("done_err", int'(mon_err), int'(bad));
            check("busy_cycles", busy_cnt, nbusy);
            check("done_latency", cyc, nbusy + 1);
            @(negedge clock);
            check("done_single_pulse", int'(mon_done), 0);
            check("err_held", int'(mon_err), int'(bad));
        end
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic reset_during_wr();
        int nbusy, cyc;
        bit bad;
        model_op(0, 500, 9000, 2, 2, 1, nbusy, bad);
        exp_q.push_back(model_q[0]);
        @(posedge clock);
        #1;
        sel = 1'b0;
        mode = 2'b00;
        src_base = ADDR_W'(500);
        dst_base = ADDR_W'(9000);
        src_w = DIM_W'(2);
        src_h = DIM_W'(2);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clock);
            cyc++;
            if (mon_we) break;
        end
        check("reset_wr_reached", int'(mon_we), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_we", int'(mon_we), 0);
        check("reset_busy", int'(mon_busy), 0);
        check("reset_addr", int'(mon_addr), 0);
        check("reset_wdata", int'(mon_wdata), 0);
        @(negedge clock);
        reset_n = 1'b1;
        check("reset_queue", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int s, m, k, w, h, sb, db;
        for (int a = 0; a < MEM_N; a++) mem[a] = PIX_W'($urandom);
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_busy", int'(bus2.busy | bus4.busy), 0);
        check("rst_done", int'(bus2.done | bus4.done), 0);
        check("rst_err", int'(bus2.err | bus4.err), 0);
        check("rst_we", int'(bus2.mem_we | bus4.mem_we), 0);
        check("rst_addr", int'(bus2.mem_addr), 0);
        check("rst_wdata", int'(bus2.mem_wdata), 0);
        reset_n = 1'b1;

        mem[0] = 8'd10; mem[1] = 8'd20; mem[320] = 8'd30; mem[321] = 8'd40;
        run_op(0, 0, 0, 1000, 2, 2, -1, 0, 0, 0);
        check("rep_1000", int'(mem[1000]), 10);
        check("rep_1321", int'(mem[1321]), 10);
        check("rep_1003", int'(mem[1003]), 20);
        check("rep_1640", int'(mem[1640]), 30);
        check("rep_1963", int'(mem[1963]), 40);

        for (int i = 0; i < 4; i++) begin
            mem[2000 + i] = 8'(i);
            mem[2320 + i] = 8'(i + 4);
        end
        run_op(0, 1, 2000, 3000, 4, 2, -1, 0, 0, 0);
        check("avg_dst0", int'(mem[3000]), 2);
        check("avg_dst1", int'(mem[3001]), 4);

        mem[4000] = 8'd255; mem[4001] = 8'd255; mem[4320] = 8'd255; mem[4321] = 8'd255;
        run_op(0, 1, 4000, 5000, 2, 2, -1, 0, 0, 0);
        check("avg_255", int'(mem[5000]), 255);

        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 8; x++) mem[y*STRIDE + x] = 8'(y*STRIDE + x);
        run_op(1, 2, 0, 7000, 8, 4, -1, 0, 0, 0);
        check("dec_dst0", int'(mem[7000]), 0);
        check("dec_dst1", int'(mem[7001]), 4);

        run_op(0, 1, 100, 8000, 3, 2, -1, 0, 0, 0);
        run_op(1, 3, 100, 8000, 0, 2, -1, 0, 0, 0);
        run_op(0, 0, 600, 20000, 4, 4, 3, 5, 0, 0);
        run_op(0, 3, 11000, 21000, 5, 3, -1, 0, 1, 0);
        run_op(1, 0, 12000, 22000, 2, 2, -1, 0, 0, 1);
        reset_during_wr();
        run_op(0, 3, 320*239 + 318, MEM_N - 2, 3, 2, -1, 0, 0, 0);
        run_op(1, 3, MEM_N - 2, 30000, 3, 2, -1, 0, 0, 0);

        for (int t = 0; t < 14; t++) begin
            s = $urandom_range(0, 1);
            m = $urandom_range(0, 3);
            k = (s != 0) ? 4 : 2;
            w = $urandom_range(1, 3) * ((m == 1 || m == 2) ? k : 1);
            h = $urandom_range(1, 3) * ((m == 1 || m == 2) ? k : 1);
            sb = $urandom_range(0, 60000);
            db = $urandom_range(120000, 250000);
            run_op(s, m, sb, db, w, h, -1, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
